calc_core: RTL and testbench
============================

CALC_CORE -- requirements
Module: calc_core

Interface
REQ-001 Parameter NREG, default 4: register-file entries; power of two, 2..16; RAW = log2(NREG).
REQ-002 Parameter DW, default 8: register and data width, 4..32.
REQ-003 Parameter FDEPTH, default 4: SEND output FIFO depth, power of two, 2..16.
REQ-004 Derived: IW = 2+3*RAW (instruction width); IMW = 2*RAW (immediate width).
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 inst_wd  in  IW  instruction word.
REQ-008 inst_vld  in  1  instruction valid.
REQ-009 inst_rdy  out  1  core can accept instruction this cycle.
REQ-010 tx_data  out  DW  SEND data to serialiser.
REQ-011 tx_vld  out  1  tx_data valid.
REQ-012 tx_rdy  in  1  serialiser accepts tx_data.
REQ-013 ovf  out  1  sticky arithmetic overflow flag.
REQ-014 inst_cnt  out  16  count of executed instructions.

Function
REQ-015 Instruction executes in the cycle where inst_vld & inst_rdy; nothing happens otherwise.
REQ-016 Encoding {op[1:0], ra, f1, f2}, each register field RAW bits, MSB first; op 00 PUSH, 01 ADD, 10 MULT, 11 SEND.
REQ-017 PUSH: R[ra] <= zero-extended immediate {f1,f2} (IMW bits, truncated to DW if IMW > DW).
REQ-018 ADD: R[f2] <= R[ra] + R[f1]; MULT: R[f2] <= R[ra] * R[f1]; result reduced to DW bits.
REQ-019 SEND: R[ra] written to FIFO tail; f1, f2 ignored.
REQ-020 Register write visible to an instruction accepted in the next cycle (no hazard stall; back-to-back dependent instructions use updated value).
REQ-021 Overflow: ADD/MULT true result > 2^DW-1 sets ovf on the executing edge; ovf clears only on reset.
REQ-022 inst_rdy = !fifo_full, combinational from registered state only; never depends on inst_vld or tx_rdy.
REQ-023 FIFO full with SEND pending: instruction held by producer; non-SEND instructions equally stalled (in-order).
REQ-024 tx_vld = !fifo_empty; tx_data = FIFO head; pop on tx_vld & tx_rdy.
REQ-025 Simultaneous push and pop: both take effect; occupancy unchanged; order preserved.
REQ-026 FIFO pointers wrap modulo FDEPTH; occupancy counter RAW-independent, log2(FDEPTH)+1 bits.
REQ-027 tx_data stable while tx_vld & !tx_rdy.
REQ-028 inst_cnt increments by 1 per executed instruction, wraps 0xFFFF -> 0x0000.

Reset
REQ-029 rst_n low at an edge: all R[i]=0, FIFO empty (tx_vld=0), ovf=0, inst_cnt=0, inst_rdy=1 after that edge.
REQ-030 Reset mid-operation discards FIFO contents and any instruction presented that cycle.

Configuration
REQ-031 Macro CALC_CORE_SAT_EN defined: ADD/MULT results clamp to 2^DW-1 on overflow; ovf still set.
REQ-032 CALC_CORE_SAT_EN undefined: results wrap modulo 2^DW; no saturation logic present.

Structure
REQ-033 Package calc_pkg holds: opcode enum (OP_PUSH, OP_ADD, OP_MULT, OP_SEND), field-width helper functions for IW/IMW.
REQ-034 Sub-module calc_fifo (parametrised DW, FDEPTH, synchronous active-low rst_n) implements the SEND FIFO.
REQ-035 Register file and decode stay in calc_core; no other sub-modules.

Verification (NREG=4, DW=8, FDEPTH=4)
REQ-036 PUSH r0,4; PUSH r1,3; MULT 0,1,2; ADD 2,0,3; SEND 0..3, tx_rdy=1 -> tx_data 4,3,12,16 in order; inst_cnt=8; ovf=0.
REQ-037 PUSH r0,15; PUSH r1,15; MULT 0,1,2; MULT 2,2,3 -> r2=225, r3=193, ovf=1; with CALC_CORE_SAT_EN r3=255.
REQ-038 tx_rdy=0, 5 SENDs offered -> 4 accepted, inst_rdy=0; tx_rdy=1 -> 4 values drain in order, 5th then accepted.
REQ-039 r0=1, ADD 0,0,0 on three consecutive cycles (inst_vld held) -> r0 = 2,4,8.
REQ-040 FIFO holding 2 entries, rst_n low one cycle -> next cycle tx_vld=0, all registers 0, ovf=0, inst_cnt=0.
REQ-041 FIFO full, tx_rdy=1 and SEND offered same cycle -> inst_rdy=0, pop only; SEND accepted next cycle.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: opcode type and instruction field-width helpers shared by calc_core.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'b00,
        OP_ADD  = 2'b01,
        OP_MULT = 2'b10,
        OP_SEND = 2'b11
    } op_t;

    localparam int OP_W = 2;

    // Full instruction width: opcode plus three register-sized fields.
    function automatic int calc_iw(input int raw);
        return OP_W + 3 * raw;
    endfunction

    // Immediate width: the two trailing register fields concatenated.
    function automatic int calc_imw(input int raw);
        return 2 * raw;
    endfunction

endpackage

// File: rtl/calc_fifo.sv
// calc_fifo: SEND output FIFO. Validity is governed by the occupancy counter,
// so reset only clears pointers/count and leaves storage untouched.
module calc_fifo #(
    parameter int DW     = 8,
    parameter int FDEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(FDEPTH);
    localparam int CW = $clog2(FDEPTH) + 1;

    logic [DW-1:0] mem [FDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(FDEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write at the tail; a full FIFO never overwrites the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks push/pop balance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/calc_core.sv
// calc_core: small register machine (PUSH/ADD/MULT/SEND) whose SEND results
// leave through a FIFO towards a serialiser.
// Optional feature macro CALC_CORE_SAT_EN: ADD/MULT clamp to all-ones on overflow
// instead of wrapping.
module calc_core
    import calc_pkg::*;
#(
    parameter  int NREG   = 4,
    parameter  int DW     = 8,
    parameter  int FDEPTH = 4,
    localparam int RAW    = $clog2(NREG),
    localparam int IW     = calc_iw(RAW),
    localparam int IMW    = calc_imw(RAW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] inst_wd,
    input  logic          inst_vld,
    output logic          inst_rdy,
    output logic [DW-1:0] tx_data,
    output logic          tx_vld,
    input  logic          tx_rdy,
    output logic          ovf,
    output logic [15:0]   inst_cnt
);

    logic [DW-1:0]   regs [NREG];
    op_t             op;
    logic [RAW-1:0]  ra;
    logic [RAW-1:0]  f1;
    logic [RAW-1:0]  f2;
    logic [IMW-1:0]  imm;
    logic [DW-1:0]   imm_dw;
    logic [DW-1:0]   opa;
    logic [DW-1:0]   opb;
    logic [DW:0]     sum_wide;
    logic [2*DW-1:0] prod_wide;
    logic [DW-1:0]   alu_wrap;
    logic [DW-1:0]   alu_result;
    logic            alu_ovf;
    logic            exec;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;

    assign op     = op_t'(inst_wd[IW-1 -: OP_W]);
    assign ra     = inst_wd[3*RAW-1 -: RAW];
    assign f1     = inst_wd[2*RAW-1 -: RAW];
    assign f2     = inst_wd[RAW-1:0];
    assign imm    = {f1, f2};
    assign imm_dw = DW'(imm);
    assign opa    = regs[ra];
    assign opb    = regs[f1];

    // Ready depends only on registered FIFO state, so a stalled producer
    // simply holds its instruction until space appears.
    assign inst_rdy  = !fifo_full;
    assign exec      = inst_vld && inst_rdy;
    assign fifo_push = exec && (op == OP_SEND);
    assign tx_vld    = !fifo_empty;
    assign fifo_pop  = tx_vld && tx_rdy;

    // Full-width arithmetic so overflow is read straight off the carry/high half.
    always_comb begin
        sum_wide  = {1'b0, opa} + {1'b0, opb};
        prod_wide = {{DW{1'b0}}, opa} * {{DW{1'b0}}, opb};
        if (op == OP_MULT) begin
            alu_ovf  = |prod_wide[2*DW-1:DW];
            alu_wrap = prod_wide[DW-1:0];
        end else begin
            alu_ovf  = sum_wide[DW];
            alu_wrap = sum_wide[DW-1:0];
        end
`ifdef CALC_CORE_SAT_EN
        alu_result = alu_ovf ? {DW{1'b1}} : alu_wrap;
`else
        alu_result = alu_wrap;
`endif
    end

    // Register file write-back; new values are visible to the next instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (exec) begin
            case (op)
                OP_PUSH:         regs[ra] <= imm_dw;
                OP_ADD, OP_MULT: regs[f2] <= alu_result;
                default:         ;
            endcase
        end
    end

    // Sticky overflow flag and executed-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            inst_cnt <= '0;
        end else if (exec) begin
            inst_cnt <= inst_cnt + 16'd1;
            if (((op == OP_ADD) || (op == OP_MULT)) && alu_ovf) begin
                ovf <= 1'b1;
            end
        end
    end

    calc_fifo #(
        .DW    (DW),
        .FDEPTH(FDEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_data(opa),
        .pop      (fifo_pop),
        .head     (tx_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_calc_core.sv
// tb_calc_core: randomized and directed stimulus against an arithmetic reference
// model; SEND results go through an expected-value queue checked by a monitor.
module tb_calc_core;

    localparam int NREG   = 4;
    localparam int DW     = 8;
    localparam int FDEPTH = 4;
    localparam int RAW    = $clog2(NREG);
    localparam int IW     = 2 + 3 * RAW;
    localparam longint MAXV = (64'd1 << DW) - 1;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [IW-1:0] inst_wd  = '0;
    logic          inst_vld = 1'b0;
    logic          inst_rdy;
    logic [DW-1:0] tx_data;
    logic          tx_vld;
    logic          tx_rdy   = 1'b0;
    logic          ovf;
    logic [15:0]   inst_cnt;

    calc_core #(.NREG(NREG), .DW(DW), .FDEPTH(FDEPTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .inst_wd (inst_wd),
        .inst_vld(inst_vld),
        .inst_rdy(inst_rdy),
        .tx_data (tx_data),
        .tx_vld  (tx_vld),
        .tx_rdy  (tx_rdy),
        .ovf     (ovf),
        .inst_cnt(inst_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint m_reg [NREG];
    bit     m_ovf;
    int     m_cnt;
    int     m_occ;
    longint exp_q [$];
    longint obs_q [$];
    longint want_q [$];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [IW-1:0] enc(input int op, input int ra, input int f1, input int f2);
        return IW'((op << (3 * RAW)) | (ra << (2 * RAW)) | (f1 << RAW) | f2);
    endfunction

    // Architectural effect of one accepted instruction, from the plain arithmetic rules.
    task automatic modelExec(input logic [IW-1:0] wd);
        int w, op, ra, f1, f2;
        longint truev;
        w  = int'(wd);
        op = (w >> (3 * RAW)) % 4;
        ra = (w >> (2 * RAW)) % NREG;
        f1 = (w >> RAW) % NREG;
        f2 = w % NREG;
        case (op)
            0: m_reg[ra] = longint'(f1 * NREG + f2) % (MAXV + 1);
            1, 2: begin
                truev = (op == 1) ? m_reg[ra] + m_reg[f1] : m_reg[ra] * m_reg[f1];
                if (truev > MAXV) begin
                    m_ovf = 1'b1;
`ifdef CALC_CORE_SAT_EN
                    truev = MAXV;
`endif
                end
                m_reg[f2] = truev % (MAXV + 1);
            end
            default: begin
                exp_q.push_back(m_reg[ra]);
                m_occ++;
            end
        endcase
        m_cnt = (m_cnt + 1) % 65536;
    endtask

    // One clock cycle: drive, check handshake outputs mid-cycle, advance model, check state.
    task automatic applyStimulus(input bit vld, input logic [IW-1:0] wd, input bit rdy, output bit accepted);
        bit popping;
        inst_vld = vld;
        inst_wd  = wd;
        tx_rdy   = rdy;
        @(negedge clk);
        checkOutput("inst_rdy", inst_rdy, 64'(m_occ < FDEPTH));
        checkOutput("tx_vld", tx_vld, 64'(m_occ > 0));
        accepted = vld && (m_occ < FDEPTH);
        popping  = rdy && (m_occ > 0);
        if (accepted) modelExec(wd);
        if (popping) m_occ--;
        @(posedge clk);
        #1;
        checkOutput("ovf", ovf, 64'(m_ovf));
        checkOutput("inst_cnt", inst_cnt, 64'(m_cnt));
    endtask

    task automatic sendInst(input logic [IW-1:0] wd, input bit rdy);
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) applyStimulus(1'b1, wd, rdy, acc);
        inst_vld = 1'b0;
        if (!acc) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        bit acc;
        for (int n = 0; n < 4 * FDEPTH + 4 && m_occ > 0; n++) applyStimulus(1'b0, '0, 1'b1, acc);
        checkOutput("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic doReset(input bit vld, input logic [IW-1:0] wd);
        rst_n    = 1'b0;
        inst_vld = vld;
        inst_wd  = wd;
        tx_rdy   = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        inst_vld = 1'b0;
        for (int i = 0; i < NREG; i++) m_reg[i] = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
        m_occ = 0;
        exp_q.delete();
        checkOutput("rst_tx_vld", tx_vld, 64'd0);
        checkOutput("rst_inst_rdy", inst_rdy, 64'd1);
        checkOutput("rst_ovf", ovf, 64'd0);
        checkOutput("rst_inst_cnt", inst_cnt, 64'd0);
    endtask

    task automatic setWant(input int n, input longint a, input longint b, input longint c,
                           input longint d, input longint e);
        longint v [5];
        v = '{a, b, c, d, e};
        want_q.delete();
        for (int i = 0; i < n; i++) want_q.push_back(v[i]);
    endtask

    // Compare observed SEND outputs against fixed expected values.
    task automatic checkObs(input string name);
        checkOutput({name, "_count"}, 64'(obs_q.size()), 64'(want_q.size()));
        for (int i = 0; i < want_q.size(); i++) begin
            checkOutput(name, (i < obs_q.size()) ? 64'(obs_q[i]) : 64'hDEAD, 64'(want_q[i]));
        end
        obs_q.delete();
    endtask

    // Monitor: pops expected SEND data whenever the DUT hands a word over.
    bit            held = 1'b0;
    logic [DW-1:0] held_data;
    always @(negedge clk) begin
        if (rst_n && tx_vld) begin
            if (held) checkOutput("tx_stable", tx_data, held_data);
            if (tx_rdy) begin
                obs_q.push_back(longint'(tx_data));
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL tx_unexpected: got %0d expected no output", tx_data);
                end else begin
                    checkOutput("tx_data", tx_data, 64'(exp_q.pop_front()));
                end
                held = 1'b0;
            end else begin
                held      = 1'b1;
                held_data = tx_data;
            end
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        bit acc;
        longint r3;
        doReset(1'b0, '0);
        obs_q.delete();

        // Basic program: 4, 3, 4*3, 12+4
        sendInst(enc(0, 0, 1, 0), 1'b1);
        sendInst(enc(0, 1, 0, 3), 1'b1);
        sendInst(enc(2, 0, 1, 2), 1'b1);
        sendInst(enc(1, 2, 0, 3), 1'b1);
        for (int r = 0; r < 4; r++) sendInst(enc(3, r, 0, 0), 1'b1);
        drain();
        setWant(4, 4, 3, 12, 16, 0);
        checkObs("seq_basic");
        checkOutput("seq_basic_cnt", inst_cnt, 64'd8);
        checkOutput("seq_basic_ovf", ovf, 64'd0);

        // Back-to-back dependent ADDs with valid held
        sendInst(enc(0, 0, 0, 1), 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, enc(1, 0, 0, 0), 1'b1, acc);
        sendInst(enc(3, 0, 0, 0), 1'b1);
        drain();
        setWant(1, 8, 0, 0, 0, 0);
        checkObs("dep_add");

        // Overflow: 15*15 = 225, 225*225 overflows
        sendInst(enc(0, 0, 3, 3), 1'b1);
        sendInst(enc(0, 1, 3, 3), 1'b1);
        sendInst(enc(2, 0, 1, 2), 1'b1);
        sendInst(enc(2, 2, 2, 3), 1'b1);
        sendInst(enc(3, 2, 0, 0), 1'b1);
        sendInst(enc(3, 3, 0, 0), 1'b1);
        drain();
`ifdef CALC_CORE_SAT_EN
        r3 = 255;
`else
        r3 = 193;
`endif
        setWant(2, 225, r3, 0, 0, 0);
        checkObs("ovf_seq");
        checkOutput("ovf_set", ovf, 64'd1);

        // Backpressure: fill FIFO, stall 5th SEND, then release with simultaneous pop
        for (int r = 0; r < 4; r++) applyStimulus(1'b1, enc(3, r, 0, 0), 1'b0, acc);
        applyStimulus(1'b1, enc(3, 0, 0, 0), 1'b0, acc);
        checkOutput("full_stall_rdy", inst_rdy, 64'd0);
        applyStimulus(1'b1, enc(3, 0, 0, 0), 1'b0, acc);
        checkOutput("full_tx_vld", tx_vld, 64'd1);
        sendInst(enc(3, 0, 0, 0), 1'b1);
        drain();
        setWant(5, 15, 15, 225, r3, 15);
        checkObs("backpressure");

        // Reset with two entries queued and an instruction presented
        sendInst(enc(3, 0, 0, 0), 1'b0);
        sendInst(enc(3, 2, 0, 0), 1'b0);
        doReset(1'b1, enc(0, 1, 2, 2));
        for (int r = 0; r < 4; r++) sendInst(enc(3, r, 0, 0), 1'b1);
        drain();
        setWant(4, 0, 0, 0, 0, 0);
        checkObs("after_reset");

        // Randomized traffic with one mid-run reset
        for (int n = 0; n < 400; n++) begin
            if (n == 200) doReset(1'b1, IW'($urandom));
            applyStimulus(($urandom % 4) != 0, IW'($urandom), ($urandom % 3) != 0, acc);
        end
        inst_vld = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
